// File: rtl/reg_bus_pkg.sv
// Shared encodings for the register-bus initiator: command opcodes, FSM states, default widths.
package reg_bus_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int IDX_W_DEF  = 4;

   typedef enum logic [1:0] {
      OP_RD  = 2'b00,
      OP_LDI = 2'b01,
      OP_MOV = 2'b10,
      OP_RSV = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE,
      R_SETUP,
      R_STROBE,
      TURN,
      W_SETUP,
      W_STROBE,
      W_HOLD,
      DONE
   } state_e;

endpackage

// File: rtl/strobe_counter.sv
// Down-counter timing the strobe and turnaround phases; done while the count sits at zero.
module strobe_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] cnt,
   output logic         done
);

   always_ff @(posedge clk) begin
      if (!reset)    cnt <= '0;
      else if (load) cnt <= load_val;
      else if (dec)  cnt <= cnt - W'(1);
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/reg_bus_master.sv
// Sequences index/rEn/wEn/bus on the shared tri-state register bus for RD, LDI and MOV commands.
module reg_bus_master
   import reg_bus_pkg::*;
#(
   parameter int DATA_W        = DATA_W_DEF,
   parameter int IDX_W         = IDX_W_DEF,
   parameter int NUM_REGS      = 4,
   parameter int STROBE_CYCLES = 1,
   parameter int TURNAROUND    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [IDX_W-1:0]  cmd_src,
   input  logic [IDX_W-1:0]  cmd_dst,
   input  logic [DATA_W-1:0] cmd_imm,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [DATA_W-1:0] rsp_data,
   output logic [IDX_W-1:0]  index,
   output logic              rEn,
   output logic              wEn,
   inout  wire  [DATA_W-1:0] bus
);

   localparam int CNT_MAX = (STROBE_CYCLES > TURNAROUND) ? STROBE_CYCLES : TURNAROUND;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   state_e              state, nxt;
   op_e                 op_in;
   logic                cmd_err, is_mov, drive_en;
   logic [IDX_W-1:0]    dst_q;
   logic [DATA_W-1:0]   data_q;
   logic                cnt_load, cnt_dec, cnt_done;
   logic [CNT_W-1:0]    cnt_val, cnt;

   assign op_in = op_e'(cmd_op);

   // Any index field the op actually uses must be in range.
   always_comb begin
      cmd_err = (op_in == OP_RSV);
      if ((op_in == OP_RD || op_in == OP_MOV) && (32'(cmd_src) >= NUM_REGS)) cmd_err = 1'b1;
      if ((op_in == OP_LDI || op_in == OP_MOV) && (32'(cmd_dst) >= NUM_REGS)) cmd_err = 1'b1;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:     if (cmd_valid) nxt = cmd_err ? DONE : ((op_in == OP_LDI) ? W_SETUP : R_SETUP);
         R_SETUP:  nxt = R_STROBE;
         R_STROBE: if (cnt_done) nxt = TURN;
         TURN:     if (cnt_done) nxt = is_mov ? W_SETUP : DONE;
         W_SETUP:  nxt = W_STROBE;
         W_STROBE: if (cnt_done) nxt = W_HOLD;
         W_HOLD:   nxt = DONE;
         DONE:     nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end

   // Counter is loaded on entry to each timed state and has run down to zero by its exit.
   assign cnt_load = (nxt != state) && (nxt == R_STROBE || nxt == W_STROBE || nxt == TURN);
   assign cnt_val  = (nxt == TURN) ? CNT_W'(TURNAROUND - 1) : CNT_W'(STROBE_CYCLES - 1);
   assign cnt_dec  = (state == R_STROBE || state == W_STROBE || state == TURN) && !cnt_done;

   strobe_counter #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (cnt_val),
      .cnt      (cnt),
      .done     (cnt_done)
   );

   // Outputs are registered decodes of the next state so they change exactly with the state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         rEn       <= 1'b0;
         wEn       <= 1'b0;
         drive_en  <= 1'b0;
         index     <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
         data_q    <= '0;
         dst_q     <= '0;
         is_mov    <= 1'b0;
      end else begin
         state     <= nxt;
         cmd_ready <= (nxt == IDLE);
         rEn       <= (nxt == R_STROBE);
         wEn       <= (nxt == W_STROBE);
         drive_en  <= (nxt inside {W_SETUP, W_STROBE, W_HOLD});
         rsp_valid <= (nxt == DONE);
         rsp_err   <= (nxt == DONE) && (state == IDLE);
         if (state == IDLE && cmd_valid) begin
            is_mov <= (op_in == OP_MOV);
            dst_q  <= cmd_dst;
            if (!cmd_err && op_in == OP_LDI) data_q <= cmd_imm;
         end
         if (state == R_STROBE && cnt_done) data_q <= bus;
         if (nxt == R_SETUP) index <= cmd_src;
         if (nxt == W_SETUP) index <= (state == IDLE) ? cmd_dst : dst_q;
         if (nxt == DONE && state != IDLE) rsp_data <= data_q;
      end
   end

   assign bus = drive_en ? data_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_reg_bus_master.sv
// Two masters (default timing and STROBE_CYCLES=3/TURNAROUND=2), each on its own bus with a 4-entry register file.
module tb_reg_bus_master;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       cmd_valid = 2'b00;
   logic [1:0]       cmd_ready, rsp_valid, rsp_err, rEn, wEn, drv;
   logic [1:0]       cmd_op  = 2'b00;
   logic [3:0]       cmd_src = 4'h0;
   logic [3:0]       cmd_dst = 4'h0;
   logic [15:0]      cmd_imm = 16'h0;
   logic [1:0][15:0] rsp_data;
   logic [1:0][3:0]  index;

   int total = 0;
   int bad   = 0;
   int viol  = 0;
   logic [15:0] mdl [2][4] = '{default: 16'h0};

   for (genvar k = 0; k < 2; k++) begin : g
      tri   [15:0] bus;
      logic [15:0] rf [4] = '{default: 16'h0};
      logic [1:0]  ridx = 2'b00;

      reg_bus_master #(
         .STROBE_CYCLES (k == 0 ? 1 : 3),
         .TURNAROUND    (k == 0 ? 1 : 2)
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .cmd_valid (cmd_valid[k]),
         .cmd_ready (cmd_ready[k]),
         .cmd_op    (cmd_op),
         .cmd_src   (cmd_src),
         .cmd_dst   (cmd_dst),
         .cmd_imm   (cmd_imm),
         .rsp_valid (rsp_valid[k]),
         .rsp_err   (rsp_err[k]),
         .rsp_data  (rsp_data[k]),
         .index     (index[k]),
         .rEn       (rEn[k]),
         .wEn       (wEn[k]),
         .bus       (bus)
      );

      assign drv[k] = u_dut.drive_en;
      assign bus = rEn[k] ? rf[ridx] : 16'hzzzz;
      always @(posedge rEn[k]) ridx <= index[k][1:0];
      always @(posedge wEn[k]) rf[index[k][1:0]] <= bus;
   end

   // Bus contention and simultaneous strobes must never occur.
   always @(negedge clk)
      for (int k = 0; k < 2; k++)
         if ((drv[k] && rEn[k]) || (rEn[k] && wEn[k])) viol++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int s_of(input int k); return (k == 0) ? 1 : 3; endfunction
   function automatic int t_of(input int k); return (k == 0) ? 1 : 2; endfunction

   // Reference: expected error, latency and response data; applies the write to the model.
   task automatic model_cmd(input int k, input logic [1:0] op, input logic [3:0] src,
                            input logic [3:0] dst, input logic [15:0] imm,
                            output logic err, output int lat, output logic [15:0] data);
      err  = (op == 2'd3) || (op != 2'd1 && src >= 4) || (op != 2'd0 && dst >= 4);
      data = 16'h0;
      if (err) lat = 1;
      else if (op == 2'd0) lat = 2 + s_of(k) + t_of(k);
      else if (op == 2'd1) lat = 3 + s_of(k);
      else                 lat = 4 + 2 * s_of(k) + t_of(k);
      if (!err) begin
         case (op)
            2'd0: data = mdl[k][src[1:0]];
            2'd1: begin data = imm; mdl[k][dst[1:0]] = imm; end
            default: begin data = mdl[k][src[1:0]]; mdl[k][dst[1:0]] = data; end
         endcase
      end
   endtask

   task automatic run_cmd(input int k, input logic [1:0] op, input logic [3:0] src,
                          input logic [3:0] dst, input logic [15:0] imm);
      logic e; int el; logic [15:0] ed;
      int n, lat, rc, wc;
      model_cmd(k, op, src, dst, imm, e, el, ed);
      @(negedge clk);
      n = 0;
      while (!cmd_ready[k] && n < 50) begin @(negedge clk); n++; end
      chk("ready_before", 32'(cmd_ready[k]), 1);
      cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm;
      cmd_valid[k] = 1'b1;
      @(negedge clk);
      cmd_valid[k] = 1'b0;
      lat = 1; rc = 0; wc = 0;
      while (!rsp_valid[k] && lat < 60) begin
         rc += int'(rEn[k]); wc += int'(wEn[k]);
         @(negedge clk); lat++;
      end
      chk("latency", lat, el);
      chk("rsp_err", 32'(rsp_err[k]), 32'(e));
      if (!e) chk("rsp_data", 32'(rsp_data[k]), 32'(ed));
      else    chk("err_nodrive", 32'(drv[k]), 0);
      chk("rEn_cycles", rc, (!e && op != 2'd1) ? s_of(k) : 0);
      chk("wEn_cycles", wc, (!e && op != 2'd0) ? s_of(k) : 0);
      @(negedge clk);
      chk("rsp_pulse", 32'(rsp_valid[k]), 0);
      chk("ready_after", 32'(cmd_ready[k]), 1);
   endtask

   task automatic b2b(input int k, input int n);
      logic e; int el; logic [15:0] ed;
      int acc, pend, issued, nrsp;
      acc = 0; pend = 0; issued = 0; nrsp = 0; e = 1'b0; el = 0; ed = 16'h0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (rsp_valid[k]) begin
            nrsp++;
            chk("b2b_spurious_rsp", pend, 1);
            chk("b2b_latency", c - acc, el);
            chk("b2b_err", 32'(rsp_err[k]), 32'(e));
            if (!e) chk("b2b_data", 32'(rsp_data[k]), 32'(ed));
            pend = 0;
         end
         if (cmd_ready[k]) begin
            chk("b2b_ready_busy", pend, 0);
            if (issued == n) begin cmd_valid[k] = 1'b0; break; end
            cmd_op  = 2'($urandom_range(0, 3));
            cmd_src = 4'($urandom_range(0, 4));
            cmd_dst = 4'($urandom_range(0, 4));
            cmd_imm = 16'($urandom);
            model_cmd(k, cmd_op, cmd_src, cmd_dst, cmd_imm, e, el, ed);
            cmd_valid[k] = 1'b1;
            acc = c; pend = 1; issued++;
         end
      end
      cmd_valid[k] = 1'b0;
      chk("b2b_rsp_count", nrsp, n);
      chk("b2b_pending", pend, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(cmd_ready), 3);
      chk("rst_strobes", 32'({rEn, wEn}), 0);
      chk("rst_rsp", 32'({rsp_valid, rsp_err}), 0);
      chk("rst_data", 32'(rsp_data[0]), 0);
      chk("rst_index", 32'(index), 0);
      chk("rst_drive", 32'(drv), 0);
      reset = 1'b1;

      run_cmd(0, 2'd1, 4'd0, 4'd2, 16'hA5A5);
      run_cmd(0, 2'd0, 4'd2, 4'd0, 16'h0);
      run_cmd(0, 2'd1, 4'd0, 4'd1, 16'h1234);
      run_cmd(0, 2'd2, 4'd1, 4'd3, 16'h0);
      run_cmd(0, 2'd0, 4'd3, 4'd0, 16'h0);
      run_cmd(0, 2'd0, 4'd1, 4'd0, 16'h0);
      run_cmd(0, 2'd3, 4'd0, 4'd0, 16'h0);
      run_cmd(0, 2'd0, 4'd4, 4'd0, 16'h0);
      run_cmd(0, 2'd2, 4'd0, 4'd7, 16'h0);
      run_cmd(0, 2'd1, 4'd0, 4'd1, 16'hBEEF);

      // Abort a MOV r1->r3 in W_SETUP; r3 must keep its old value.
      @(negedge clk);
      cmd_op = 2'd2; cmd_src = 4'd1; cmd_dst = 4'd3;
      cmd_valid[0] = 1'b1;
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("wsetup_drive", 32'(drv[0]), 1);
      chk("wsetup_wen", 32'(wEn[0]), 0);
      chk("wsetup_bus", 32'(g[0].bus), 32'(mdl[0][1]));
      reset = 1'b0;
      @(negedge clk);
      chk("abort_strobes", 32'({rEn[0], wEn[0]}), 0);
      chk("abort_drive", 32'(drv[0]), 0);
      chk("abort_ready", 32'(cmd_ready[0]), 1);
      chk("abort_rsp", 32'(rsp_valid[0]), 0);
      reset = 1'b1;
      run_cmd(0, 2'd0, 4'd3, 4'd0, 16'h0);
      run_cmd(0, 2'd2, 4'd2, 4'd2, 16'h0);
      run_cmd(0, 2'd0, 4'd2, 4'd0, 16'h0);

      run_cmd(1, 2'd1, 4'd0, 4'd1, 16'h1234);
      run_cmd(1, 2'd2, 4'd1, 4'd3, 16'h0);
      run_cmd(1, 2'd0, 4'd3, 4'd0, 16'h0);

      b2b(0, 25);
      b2b(1, 25);

      chk("contention", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
